op_dispatcher: RTL and testbench

//  Initiator side of OpHandler_IF: accepts decoded Op_st words from the upstream parser/FIFO,

---
 rtl/op_dispatcher_pkg.sv | 34 +++
 rtl/op_pkg.sv | 21 ++
 rtl/op_dispatcher.sv | 131 +++++++++++++
 tb/tb_op_dispatcher.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_dispatcher_pkg.sv
// Routing classes and FSM states for op_dispatcher, plus the command-to-route decoder.
package op_dispatcher_pkg;
    import op_pkg::*;

    typedef enum logic [2:0] {
        ROUTE_LIN   = 3'd0,
        ROUTE_CIRC  = 3'd1,
        ROUTE_SERVO = 3'd2,
        ROUTE_MODE  = 3'd3,
        ROUTE_BAD   = 3'd4
    } route_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_TRIGGER   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

    // Handler routes share their encoding with the trigger bit index.
    function automatic route_e cmd_to_route(input logic [OP_CMD_W-1:0] cmd);
        route_e r;
        case (cmd)
            OP_CMD_G00, OP_CMD_G01: r = ROUTE_LIN;
            OP_CMD_G02, OP_CMD_G03: r = ROUTE_CIRC;
            OP_CMD_M03, OP_CMD_M05: r = ROUTE_SERVO;
            OP_CMD_G90, OP_CMD_G91: r = ROUTE_MODE;
            default:                r = ROUTE_BAD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/op_pkg.sv
// Operation word shared by the parser, the dispatcher, the handlers and PositionKeeper.
package op_pkg;

    localparam int OP_CMD_W = 6;

    localparam logic [OP_CMD_W-1:0] OP_CMD_G00 = 6'h00;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G01 = 6'h01;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G02 = 6'h02;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G03 = 6'h03;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G90 = 6'h10;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G91 = 6'h11;
    localparam logic [OP_CMD_W-1:0] OP_CMD_M03 = 6'h20;
    localparam logic [OP_CMD_W-1:0] OP_CMD_M05 = 6'h21;

    typedef struct packed {
        logic [OP_CMD_W-1:0] cmd;
        logic [15:0]         x;
        logic [15:0]         y;
    } op_st;

endpackage

// File: rtl/op_dispatcher.sv
// Initiator side of the op handler interface: takes one op at a time, triggers its handler
// or holds mode ops on out_op, and flags unknown commands and unacknowledged triggers.
module op_dispatcher
    import op_pkg::*;
    import op_dispatcher_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int MODE_HOLD   = 2,
    parameter int TMR_BITS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  op_st       in_op,
    input  logic       in_valid,
    output logic       in_rdy,
    output op_st       out_op,
    output logic       lin_trigger,
    input  logic       lin_rdy,
    output logic       circ_trigger,
    input  logic       circ_rdy,
    output logic       servo_trigger,
    input  logic       servo_rdy,
    output logic       busy,
    output logic       err_unknown,
    output logic       err_timeout,
    output logic [2:0] dbg_state
);

    localparam logic [TMR_BITS-1:0] ACK_LIMIT  = TMR_BITS'(ACK_TIMEOUT);
    localparam logic [TMR_BITS-1:0] HOLD_LIMIT = TMR_BITS'(MODE_HOLD);

    // Upstream handshake: a transfer happens on a clk edge where in_valid, in_rdy and clk_en
    // are all high; in_rdy depends only on the state register, never on in_valid.

    state_e              state_q;
    op_st                out_op_q;
    logic [2:0]          trig_q;
    logic [TMR_BITS-1:0] tmr_q;
    logic                err_unknown_q;
    logic                err_timeout_q;

    route_e              route;
    logic                target_rdy;
    logic [TMR_BITS-1:0] tmr_inc;

    assign route   = cmd_to_route(out_op_q.cmd);
    assign tmr_inc = tmr_q + 1'b1;

    // Only the addressed handler's rdy is ever looked at.
    always_comb begin
        target_rdy = 1'b0;
        case (route)
            ROUTE_LIN:   target_rdy = lin_rdy;
            ROUTE_CIRC:  target_rdy = circ_rdy;
            ROUTE_SERVO: target_rdy = servo_rdy;
            default:     target_rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            out_op_q      <= '0;
            trig_q        <= '0;
            tmr_q         <= '0;
            err_unknown_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        out_op_q <= in_op;
                        state_q  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    tmr_q <= '0;
                    case (route)
                        ROUTE_MODE: state_q <= ST_HOLD;
                        ROUTE_BAD: begin
                            err_unknown_q <= 1'b1;
                            state_q       <= ST_IDLE;
                        end
                        default: begin
                            // A busy handler is waited on here, never triggered.
                            if (target_rdy) begin
                                trig_q  <= 3'b001 << route;
                                state_q <= ST_TRIGGER;
                            end
                        end
                    endcase
                end
                ST_TRIGGER: begin
                    tmr_q <= tmr_inc;
                    if (!target_rdy) begin
                        trig_q  <= '0;
                        state_q <= ST_WAIT_DONE;
                    end else if (tmr_inc == ACK_LIMIT) begin
                        trig_q        <= '0;
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (target_rdy) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    tmr_q <= tmr_inc;
                    if (tmr_inc == HOLD_LIMIT) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_rdy        = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign out_op        = out_op_q;
    assign lin_trigger   = trig_q[0];
    assign circ_trigger  = trig_q[1];
    assign servo_trigger = trig_q[2];
    assign err_unknown   = err_unknown_q;
    assign err_timeout   = err_timeout_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_op_dispatcher.sv
// Bench for op_dispatcher: behavioural handlers, a trigger scoreboard and directed scenarios.
module tb_op_dispatcher;
    import op_pkg::*;
    import op_dispatcher_pkg::*;

    localparam int W = 3 + $bits(op_st);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic clk_en;
    always #5 clk = ~clk;

    op_st       in_op;
    logic       in_valid;
    logic       in_rdy;
    op_st       out_op;
    logic       lin_trigger, circ_trigger, servo_trigger;
    logic [2:0] rdy_v = 3'b111;
    logic       busy, err_unknown, err_timeout;
    logic [2:0] dbg_state;

    op_dispatcher dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .in_op(in_op), .in_valid(in_valid), .in_rdy(in_rdy), .out_op(out_op),
        .lin_trigger(lin_trigger), .lin_rdy(rdy_v[0]),
        .circ_trigger(circ_trigger), .circ_rdy(rdy_v[1]),
        .servo_trigger(servo_trigger), .servo_rdy(rdy_v[2]),
        .busy(busy), .err_unknown(err_unknown), .err_timeout(err_timeout),
        .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural handlers ----------------
    // ack_dly: trigger-high samples before rdy drops (0 = never); busy_len: samples rdy stays low.
    int ack_dly [3] = '{2, 2, 2};
    int busy_len[3] = '{5, 5, 5};
    int h_st    [3] = '{0, 0, 0};
    int h_cnt   [3] = '{0, 0, 0};
    logic [2:0] trig_v;
    assign trig_v = {servo_trigger, circ_trigger, lin_trigger};

    always @(negedge clk) begin
        for (int h = 0; h < 3; h++) begin
            case (h_st[h])
                0: if (trig_v[h]) begin
                    h_cnt[h] = 1;
                    h_st[h]  = 1;
                end
                1: if (!trig_v[h]) h_st[h] = 0;
                   else h_cnt[h]++;
                default: begin
                    h_cnt[h]++;
                    if (h_cnt[h] >= busy_len[h]) begin
                        rdy_v[h] = 1'b1;
                        h_st[h]  = 0;
                    end
                end
            endcase
            if (h_st[h] == 1 && ack_dly[h] != 0 && h_cnt[h] >= ack_dly[h]) begin
                rdy_v[h] = 1'b0;
                h_st[h]  = 2;
                h_cnt[h] = 0;
            end
        end
    end

    // ---------------- trigger monitor / scoreboard ----------------
    logic [2:0] trig_prev = 3'b000;
    logic [2:0] rdy_at_edge = 3'b111;
    always @(posedge clk) rdy_at_edge <= rdy_v;

    always @(negedge clk) begin : mon
        logic [2:0]   rise;
        int           idx;
        logic [W-1:0] e;
        rise      = trig_v & ~trig_prev;
        trig_prev = trig_v;
        if ($countones(trig_v) > 1) check("trig_overlap", trig_v, {2'b00, trig_v[0]});
        if (rise != 3'b000) begin
            check("trig_onehot", $countones(trig_v), 1);
            idx = rise[0] ? 0 : (rise[1] ? 1 : 2);
            check("trig_target_rdy", rdy_at_edge[idx], 1);
            if (exp_q.size() == 0) begin
                check("trig_unexpected", rise, 0);
            end else begin
                e = exp_q.pop_front();
                check("trig_route", idx, e[W-1 -: 3]);
                check("trig_op", out_op, e[W-4:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic op_st mk(input logic [OP_CMD_W-1:0] c);
        op_st o;
        o.cmd = c;
        o.x   = 16'($urandom);
        o.y   = 16'($urandom);
        return o;
    endfunction

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_op(input op_st op, input logic [2:0] route);
        int n = 0;
        in_op    = op;
        in_valid = 1'b1;
        while (!in_rdy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check("send_in_rdy_timeout", in_rdy, 1);
        if (route <= 3'd2) exp_q.push_back({route, op});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check(tag, {busy, (exp_q.size() != 0)}, 2'b00);
        @(negedge clk);
    endtask

    // ---------------- directed and random scenarios ----------------
    initial begin : main
        int  hi, cnt, frz, r;
        logic seen_low, done, busy_gap;
        logic [OP_CMD_W-1:0] cmd;
        op_st op;

        reset = 1'b0; clk_en = 1'b1; in_valid = 1'b0; in_op = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_op", out_op, 0);
        check("rst_trig", trig_v, 0);
        check("rst_errs", {err_unknown, err_timeout}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b1;
        @(negedge clk);

        // G02: ack after 3 trigger cycles, busy for 200
        ack_dly[1] = 3; busy_len[1] = 200;
        send_op(mk(OP_CMD_G02), 3'd1);
        hi = 0; seen_low = 0; done = 0; busy_gap = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk); #1;
            if (circ_trigger) hi++;
            if (!busy) busy_gap = 1;
            if (!rdy_v[1]) seen_low = 1;
            else if (seen_low) done = 1;
        end
        check("g02_rdy_rise_seen", done, 1);
        check("g02_trig_cycles", hi, 3);
        check("g02_busy_held", busy_gap, 0);
        check("g02_busy_at_rise", {busy, in_rdy}, 2'b10);
        @(negedge clk); #1;
        check("g02_idle_after", {busy, in_rdy}, 2'b01);

        // G01 then G03 back-to-back with in_valid held
        ack_dly = '{2, 2, 2}; busy_len = '{4, 4, 4};
        send_op(mk(OP_CMD_G01), 3'd0);
        send_op(mk(OP_CMD_G03), 3'd1);
        wait_idle("b2b_idle");

        // G91: held on out_op for MODE_HOLD+1 cycles, no trigger
        send_op(mk(OP_CMD_G91), 3'd3);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) begin
                cnt++;
                check("g91_out_cmd", out_op.cmd, OP_CMD_G91);
            end
            @(negedge clk);
        end
        check("g91_busy_cycles", cnt, 3);
        check("g91_in_rdy", in_rdy, 1);

        // Unknown cmd dropped, next G00 dispatched normally
        send_op(mk(6'h3F), 3'd4);
        @(negedge clk);
        check("bad_err_unknown", err_unknown, 1);
        check("bad_back_idle", busy, 0);
        send_op(mk(OP_CMD_G00), 3'd0);
        wait_idle("bad_then_g00_idle");
        check("bad_err_sticky", {err_unknown, err_timeout}, 2'b10);

        // G00 with lin_rdy stuck high; clk_en dropped for 5 cycles mid-trigger
        ack_dly[0] = 0;
        send_op(mk(OP_CMD_G00), 3'd0);
        hi = 0; frz = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lin_trigger) hi++;
            if (hi == 4 && frz == 0) begin
                clk_en = 1'b0;
                frz = 1;
            end else if (frz >= 1 && frz < 6) begin
                frz++;
                if (frz == 6) clk_en = 1'b1;
            end
        end
        check("to_trig_cycles", hi, 21);
        check("to_err_timeout", err_timeout, 1);
        check("to_idle", {busy, lin_trigger}, 2'b00);
        check("to_state", dbg_state, ST_IDLE);
        ack_dly[0] = 2;

        // Random handler ops, random handler timing
        for (int k = 0; k < 12; k++) begin
            r = $urandom_range(0, 2);
            ack_dly[r]  = $urandom_range(1, 4);
            busy_len[r] = $urandom_range(1, 8);
            case (r)
                0:       cmd = ($urandom_range(0, 1) != 0) ? OP_CMD_G01 : OP_CMD_G00;
                1:       cmd = ($urandom_range(0, 1) != 0) ? OP_CMD_G03 : OP_CMD_G02;
                default: cmd = ($urandom_range(0, 1) != 0) ? OP_CMD_M05 : OP_CMD_M03;
            endcase
            op = mk(cmd);
            send_op(op, r[2:0]);
        end
        wait_idle("rand_idle");

        // Reset during WAIT_DONE, then the left-busy handler is waited on in DECODE
        ack_dly[1] = 1; busy_len[1] = 80;
        send_op(mk(OP_CMD_G02), 3'd1);
        for (int i = 0; i < 20 && !(busy && !rdy_v[1] && !circ_trigger); i++) @(negedge clk);
        @(negedge clk);
        check("rst_mid_pre_state", dbg_state, ST_WAIT_DONE);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_trig", trig_v, 0);
        check("rst_mid_out_op", out_op, 0);
        check("rst_mid_errs", {err_unknown, err_timeout}, 0);
        check("rst_mid_state", dbg_state, ST_IDLE);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_op(mk(OP_CMD_G03), 3'd1);
        repeat (5) @(negedge clk);
        check("rst_wait_decode", dbg_state, ST_DECODE);
        check("rst_no_trig", circ_trigger, 0);
        wait_idle("rst_final_idle");

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
